// File: rtl/i2s_rx_fifo.sv
// I2S master receiver. Generates the bit clock and word select, captures one
// channel MSB first with the standard one-bit delay, sign-extends each sample
// to 32 bits and buffers it in a first-word-fall-through FIFO.
//
// Handshake: a sample leaves the FIFO on every rising HCLK edge where
// sample_valid && sample_ready; sample_data is stable while sample_valid is
// high and sample_ready is low, and reads zero whenever the FIFO is empty.
module i2s_rx_fifo #(
    parameter int CLK_DIV    = 4,
    parameter int SAMPLE_W   = 24,
    parameter int FIFO_DEPTH = 8,
    parameter int CHANNEL    = 0,
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             en,
    output logic             i2s_clk,
    output logic             ws,
    input  logic             I2S_in,
    output logic [31:0]      sample_data,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic [LVL_W-1:0] fifo_level,
    output logic             overflow,
    input  logic             ovf_clr
);

    localparam int   DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int   AW    = $clog2(FIFO_DEPTH);
    localparam logic CH_WS = (CHANNEL != 0);

    logic [DIV_W-1:0]    div;
    logic [4:0]          bit_cnt;
    logic [SAMPLE_W-1:0] shreg;
    logic                push_req;
    logic [31:0]         push_word;

    logic [31:0]         mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;

    // Clock-generation events, decoded from the divider before it wraps.
    logic div_wrap;
    logic bclk_rise;
    logic in_slot;
    logic in_word;
    logic word_done;

    assign div_wrap  = (div == DIV_W'(CLK_DIV - 1));
    assign bclk_rise = en && div_wrap && !i2s_clk;
    assign in_slot   = (ws == CH_WS);
    assign in_word   = (bit_cnt >= 5'd1) && (bit_cnt <= 5'(SAMPLE_W));
    assign word_done = (bit_cnt == 5'(SAMPLE_W));

    // Shift register with the newly sampled bit appended as LSB.
    logic [SAMPLE_W:0]   shift_ext;
    logic [SAMPLE_W-1:0] new_word;
    logic [31:0]         new_sext;

    assign shift_ext = {shreg, I2S_in};
    assign new_word  = shift_ext[SAMPLE_W-1:0];
    assign new_sext  = {{(32 - SAMPLE_W){new_word[SAMPLE_W-1]}}, new_word};

    // FIFO control.
    logic pop;
    logic full;
    logic wr_en;
    logic drop;

    assign sample_valid = (fifo_level != '0);
    assign sample_data  = sample_valid ? mem[rd_ptr] : 32'h0;
    assign pop          = sample_valid && sample_ready;
    assign full         = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign wr_en        = push_req && (!full || pop);
    assign drop         = push_req && full && !pop;

    // Bit clock divider, bit counter and word select; all idle while en is low.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            div     <= '0;
            i2s_clk <= 1'b0;
            bit_cnt <= '0;
            ws      <= 1'b0;
        end else if (!en) begin
            div     <= '0;
            i2s_clk <= 1'b0;
            bit_cnt <= '0;
            ws      <= 1'b0;
        end else if (div_wrap) begin
            div     <= '0;
            i2s_clk <= ~i2s_clk;
            if (i2s_clk) begin
                bit_cnt <= bit_cnt + 5'd1;
                if (bit_cnt == 5'd31) begin
                    ws <= ~ws;
                end
            end
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    // Sample I2S_in on the bit-clock rising edge and flag a finished word.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            shreg     <= '0;
            push_req  <= 1'b0;
            push_word <= '0;
        end else begin
            push_req <= 1'b0;
            if (!en) begin
                shreg <= '0;
            end else if (bclk_rise && in_slot && in_word) begin
                shreg <= new_word;
                if (word_done) begin
                    push_req  <= 1'b1;
                    push_word <= new_sext;
                end
            end
        end
    end

    // Sample storage; contents need no reset because level gates visibility.
    always_ff @(posedge HCLK) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_word;
        end
    end

    // Pointers and occupancy; a push into a full FIFO is accepted when a pop frees a slot.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule
